// File: rtl/waveform_duty_gen_pkg.sv
// Shared waveform mode encoding and default parameter values for waveform_duty_gen.
package waveform_duty_gen_pkg;

  localparam int DUTY_W_DEF     = 7;
  localparam int PHASE_W_DEF    = 16;
  localparam int LUT_ADDR_W_DEF = 6;
  localparam int PRESCALE_W_DEF = 6;

  typedef enum logic [1:0] {
    MODE_SINE   = 2'd0,
    MODE_TRI    = 2'd1,
    MODE_SAW    = 2'd2,
    MODE_SQUARE = 2'd3
  } mode_e;

endpackage

// File: rtl/waveform_half_lut.sv
// Combinational half-wave raised-cosine table, N/2 entries from 0 up to PEAK.
// Entries span 0..pi inclusive so the mirrored wave touches both 0 and PEAK exactly.
module waveform_half_lut
  import waveform_duty_gen_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF
) (
  input  logic [LUT_ADDR_W-2:0] addr,
  output logic [DUTY_W-1:0]     val
);

  localparam int HALF = 1 << (LUT_ADDR_W - 1);
  localparam int PEAK = 1 << (DUTY_W - 1);

  logic [DUTY_W-1:0] sine_tab [HALF];

  for (genvar g = 0; g < HALF; g++) begin : g_tab
    localparam real ANG = 3.141592653589793 * g / (HALF - 1);
    localparam int  VAL = $rtoi(PEAK * (1.0 - $cos(ANG)) / 2.0 + 0.5);
    assign sine_tab[g] = DUTY_W'(VAL);
  end

  assign val = sine_tab[addr];

endmodule

// File: rtl/waveform_duty_gen.sv
// Prescaled DDS duty-cycle generator: sine/triangle/sawtooth/square, registered at each sample tick.
// Optional macro WAVEFORM_DUTY_GEN_PHASE_OFFSET_EN adds a phase_offset lookup port.
module waveform_duty_gen
  import waveform_duty_gen_pkg::*;
#(
  parameter int DUTY_W     = DUTY_W_DEF,
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int LUT_ADDR_W = LUT_ADDR_W_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [PHASE_W-1:0]    tuning_word,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [1:0]            amp_shift,
`ifdef WAVEFORM_DUTY_GEN_PHASE_OFFSET_EN
  input  logic [LUT_ADDR_W-1:0] phase_offset,
`endif
  output logic [DUTY_W-1:0]     duty_out,
  output logic                  sample_tick,
  output logic                  cycle_wrap
);

  localparam int PEAK = 1 << (DUTY_W - 1);
  localparam int W    = DUTY_W + LUT_ADDR_W;

  logic [PRESCALE_W-1:0] count;
  logic [PHASE_W-1:0]    phase;
  logic [PHASE_W:0]      phase_sum;
  logic [LUT_ADDR_W-1:0] lut_idx;
  logic [LUT_ADDR_W-2:0] half_idx;
  logic [DUTY_W-1:0]     sine_val;
  logic [DUTY_W-1:0]     shape;
  logic                  tick;

  assign tick      = enable && (count >= prescale);
  assign phase_sum = {1'b0, phase} + {1'b0, tuning_word};

`ifdef WAVEFORM_DUTY_GEN_PHASE_OFFSET_EN
  // Offset only moves the lookup point; the accumulator and its carry are untouched.
  assign lut_idx = phase[PHASE_W-1 -: LUT_ADDR_W] + phase_offset;
`else
  assign lut_idx = phase[PHASE_W-1 -: LUT_ADDR_W];
`endif

  // Upper half of the cycle reads the table backwards: N-1-i keeps the low bits inverted.
  assign half_idx = lut_idx[LUT_ADDR_W-1] ? ~lut_idx[LUT_ADDR_W-2:0] : lut_idx[LUT_ADDR_W-2:0];

  waveform_half_lut #(
    .DUTY_W     (DUTY_W),
    .LUT_ADDR_W (LUT_ADDR_W)
  ) u_half_lut (
    .addr (half_idx),
    .val  (sine_val)
  );

  always_comb begin
    shape = '0;
    case (mode_e'(mode))
      MODE_SINE: shape = sine_val;
      MODE_TRI:  shape = DUTY_W'((W'(half_idx) << (DUTY_W - 1)) >> (LUT_ADDR_W - 1));
      MODE_SAW:  shape = DUTY_W'((W'(lut_idx) << (DUTY_W - 1)) >> LUT_ADDR_W);
      default:   shape = lut_idx[LUT_ADDR_W-1] ? '0 : DUTY_W'(PEAK);
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset || !enable) begin
      count       <= '0;
      phase       <= '0;
      duty_out    <= '0;
      sample_tick <= 1'b0;
      cycle_wrap  <= 1'b0;
    end else if (tick) begin
      count       <= '0;
      phase       <= phase_sum[PHASE_W-1:0];
      duty_out    <= shape >> amp_shift;
      sample_tick <= 1'b1;
      cycle_wrap  <= phase_sum[PHASE_W];
    end else begin
      count       <= count + PRESCALE_W'(1);
      sample_tick <= 1'b0;
      cycle_wrap  <= 1'b0;
    end
  end

endmodule
